// File: rtl/axi_wb_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to Wishbone bridge.
//   bridge_state_t      : bridge FSM state encoding
//   DefaultTimeoutRdata : read data returned when a read is aborted by timeout
package axi_wb_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrAddr,
    StWrBus,
    StWrResp,
    StRdBus,
    StRdResp
  } bridge_state_t;

  localparam logic [31:0] DefaultTimeoutRdata = 32'hDEADBEEF;

endpackage

// File: rtl/axi_lite_wb_bridge.sv
// AXI4-Lite (no BRESP/RRESP) to Wishbone classic bridge. One transaction at a
// time: each accepted AXI write or read becomes a single Wishbone cycle, and
// the result is returned on B or R. An ack timeout aborts cycles to unmapped
// addresses so the core cannot hang.
//
// Ports:
//   clk_core, rst_core            : clock, synchronous active-high reset
//   AW*/W*/B*                     : AXI write address, data and response channels
//   AR*/R*                        : AXI read address and data channels
//   core_cyc/stb/we/wstrb/addr    : Wishbone request
//   core_data_out / core_data_in  : Wishbone write / read data
//   core_ack                      : Wishbone acknowledge
//   timeout_o                     : one-cycle pulse when a cycle is aborted
module axi_lite_wb_bridge
  import axi_wb_bridge_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0]  TIMEOUT_RDATA  = DATA_WIDTH'(DefaultTimeoutRdata)
) (
  input  logic                    clk_core,
  input  logic                    rst_core,

  input  logic                    AWvalid,
  output logic                    AWready,
  input  logic [ADDR_WIDTH-1:0]   AWdata,
  input  logic [2:0]              AWprot,

  input  logic                    Wvalid,
  output logic                    Wready,
  input  logic [DATA_WIDTH-1:0]   Wdata,
  input  logic [DATA_WIDTH/8-1:0] Wstrb,

  output logic                    Bvalid,
  input  logic                    Bready,

  input  logic                    ARvalid,
  output logic                    ARready,
  input  logic [ADDR_WIDTH-1:0]   ARdata,
  input  logic [2:0]              ARprot,

  output logic                    Rvalid,
  input  logic                    RReady,
  output logic [DATA_WIDTH-1:0]   Rdata,

  output logic                    core_cyc,
  output logic                    core_stb,
  output logic                    core_we,
  output logic [DATA_WIDTH/8-1:0] core_wstrb,
  output logic [ADDR_WIDTH-1:0]   core_addr,
  output logic [DATA_WIDTH-1:0]   core_data_out,
  input  logic [DATA_WIDTH-1:0]   core_data_in,
  input  logic                    core_ack,

  output logic                    timeout_o
);

  localparam int unsigned StrbW    = DATA_WIDTH / 8;
  localparam int unsigned CntWRaw  = $clog2(TIMEOUT_CYCLES + 1);
  // Counter is kept between 8 and 32 bits regardless of the limit.
  localparam int unsigned CntW     = (CntWRaw < 8) ? 8 : ((CntWRaw > 32) ? 32 : CntWRaw);
  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CntW-1:0] CntLimit =
    CntW'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

  bridge_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [StrbW-1:0]      strb_q, strb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  aw_ready_q, aw_ready_d;
  logic                  w_ready_q, w_ready_d;
  logic                  ar_ready_q, ar_ready_d;

  logic aw_hs, w_hs, ar_hs;
  logic in_bus, timeout_hit;

  // Protection bits are accepted but carry no meaning on this bus.
  logic unused_prot;
  assign unused_prot = ^{AWprot, ARprot};

  assign aw_hs       = AWvalid && aw_ready_q;
  assign w_hs        = Wvalid && w_ready_q;
  assign ar_hs       = ARvalid && ar_ready_q;
  assign in_bus      = (state_q == StWrBus) || (state_q == StRdBus);
  assign timeout_hit = TimeoutEn && (cnt_q == CntLimit);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    cnt_d     = '0;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Writes win over reads when both are presented together.
        if (aw_hs && w_hs) begin
          addr_d  = AWdata;
          data_d  = Wdata;
          strb_d  = Wstrb;
          state_d = StWrBus;
        end else if (aw_hs) begin
          addr_d  = AWdata;
          state_d = StWrData;
        end else if (w_hs) begin
          data_d  = Wdata;
          strb_d  = Wstrb;
          state_d = StWrAddr;
        end else if (ar_hs) begin
          addr_d  = ARdata;
          state_d = StRdBus;
        end
      end
      StWrData: begin
        if (w_hs) begin
          data_d  = Wdata;
          strb_d  = Wstrb;
          state_d = StWrBus;
        end
      end
      StWrAddr: begin
        if (aw_hs) begin
          addr_d  = AWdata;
          state_d = StWrBus;
        end
      end
      StWrBus, StRdBus: begin
        // An ack on the limit cycle takes precedence over the abort.
        if (core_ack) begin
          if (state_q == StRdBus) rdata_d = core_data_in;
          state_d = (state_q == StRdBus) ? StRdResp : StWrResp;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          if (state_q == StRdBus) rdata_d = TIMEOUT_RDATA;
          state_d = (state_q == StRdBus) ? StRdResp : StWrResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrResp: begin
        if (Bready) state_d = StIdle;
      end
      StRdResp: begin
        if (RReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Readies are registered from the next state so they line up with state_q.
  always_comb begin
    aw_ready_d = (state_d == StIdle) || (state_d == StWrAddr);
    w_ready_d  = (state_d == StIdle) || (state_d == StWrData);
    ar_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      ar_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      ar_ready_q <= ar_ready_d;
    end
  end

  assign AWready       = aw_ready_q;
  assign Wready        = w_ready_q;
  assign ARready       = ar_ready_q;
  assign Bvalid        = (state_q == StWrResp);
  assign Rvalid        = (state_q == StRdResp);
  assign Rdata         = rdata_q;
  assign core_cyc      = in_bus;
  assign core_stb      = in_bus;
  assign core_we       = (state_q == StWrBus);
  assign core_wstrb    = (state_q == StWrBus) ? strb_q : '0;
  assign core_addr     = addr_q;
  assign core_data_out = data_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_axi_lite_wb_bridge.sv
// Self-checking bench for axi_lite_wb_bridge: a per-cycle vector table for the
// basic write/read flows, then hand-written sequences for priority, timeout,
// ack-at-limit and mid-transaction reset.
module tb_axi_lite_wb_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // {AWready, Wready, ARready, cyc, stb, we, Bvalid, Rvalid}
  localparam logic [7:0] C_IDLE = 8'b1110_0000;
  localparam logic [7:0] C_WADR = 8'b1000_0000;
  localparam logic [7:0] C_WBUS = 8'b0001_1100;
  localparam logic [7:0] C_RBUS = 8'b0001_1000;
  localparam logic [7:0] C_BRSP = 8'b0000_0010;
  localparam logic [7:0] C_RRSP = 8'b0000_0001;

  logic          clk_core = 1'b0;
  logic          rst_core;
  logic          AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
  logic          ARvalid, ARready, Rvalid, RReady;
  logic [AW-1:0] AWdata, ARdata, core_addr;
  logic [2:0]    AWprot, ARprot;
  logic [DW-1:0] Wdata, Rdata, core_data_out, core_data_in;
  logic [3:0]    Wstrb, core_wstrb;
  logic          core_cyc, core_stb, core_we, core_ack, timeout_o;

  axi_lite_wb_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_core      (clk_core),
    .rst_core      (rst_core),
    .AWvalid       (AWvalid),
    .AWready       (AWready),
    .AWdata        (AWdata),
    .AWprot        (AWprot),
    .Wvalid        (Wvalid),
    .Wready        (Wready),
    .Wdata         (Wdata),
    .Wstrb         (Wstrb),
    .Bvalid        (Bvalid),
    .Bready        (Bready),
    .ARvalid       (ARvalid),
    .ARready       (ARready),
    .ARdata        (ARdata),
    .ARprot        (ARprot),
    .Rvalid        (Rvalid),
    .RReady        (RReady),
    .Rdata         (Rdata),
    .core_cyc      (core_cyc),
    .core_stb      (core_stb),
    .core_we       (core_we),
    .core_wstrb    (core_wstrb),
    .core_addr     (core_addr),
    .core_data_out (core_data_out),
    .core_data_in  (core_data_in),
    .core_ack      (core_ack),
    .timeout_o     (timeout_o)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic        awv, wv, arv, bready, rready, ack;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [31:0] rdin;
    logic [7:0]  ctl;
    logic [31:0] exp_addr, exp_data;
    logic [3:0]  exp_strb;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic awv, input logic wv, input logic arv,
                              input logic bready, input logic rready, input logic ack,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [31:0] rdin,
                              input logic [7:0] ctl, input logic [31:0] exp_addr,
                              input logic [31:0] exp_data, input logic [3:0] exp_strb,
                              input logic chk_rd, input logic [31:0] exp_rd);
    vec_t v;
    v.awv = awv; v.wv = wv; v.arv = arv; v.bready = bready; v.rready = rready;
    v.ack = ack; v.addr = addr; v.wdata = wdata; v.strb = strb; v.rdin = rdin;
    v.ctl = ctl; v.exp_addr = exp_addr; v.exp_data = exp_data; v.exp_strb = exp_strb;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic idle_inputs();
    AWvalid = 1'b0; Wvalid = 1'b0; ARvalid = 1'b0; Bready = 1'b0; RReady = 1'b0;
    core_ack = 1'b0;
  endtask

  function automatic logic [7:0] ctl_now();
    return {AWready, Wready, ARready, core_cyc, core_stb, core_we, Bvalid, Rvalid};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    idle_inputs();
    rst_core = 1'b1;
    AWdata = '0; ARdata = '0; Wdata = '0; Wstrb = '0; core_data_in = '0;
    AWprot = 3'b010; ARprot = 3'b101;

    // Write: AW+W together, Bready held off one cycle
    vecs.push_back(mk(1,1,0,0,0,0, 32'h100, 32'hCAFEBABE, 4'hF, 32'h0,
                      C_IDLE, 32'h0, 32'h0, 4'h0, 0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,1, 32'h0, 32'h0, 4'h0, 32'h0,
                      C_WBUS, 32'h100, 32'hCAFEBABE, 4'hF, 0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 4'h0, 32'h0,
                      C_BRSP, 32'h0, 32'h0, 4'h0, 0, 32'h0));
    vecs.push_back(mk(0,0,0,1,0,0, 32'h0, 32'h0, 4'h0, 32'h0,
                      C_BRSP, 32'h0, 32'h0, 4'h0, 0, 32'h0));
    // Write: W leads AW by 3 cycles, partial strobe
    vecs.push_back(mk(0,1,0,0,0,0, 32'h0, 32'h00005A5A, 4'b0011, 32'h0,
                      C_IDLE, 32'h0, 32'h0, 4'h0, 0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 4'h0, 32'h0,
                      C_WADR, 32'h0, 32'h0, 4'h0, 0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 4'h0, 32'h0,
                      C_WADR, 32'h0, 32'h0, 4'h0, 0, 32'h0));
    vecs.push_back(mk(1,0,0,0,0,0, 32'h104, 32'h0, 4'h0, 32'h0,
                      C_WADR, 32'h0, 32'h0, 4'h0, 0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,1, 32'h0, 32'h0, 4'h0, 32'h0,
                      C_WBUS, 32'h104, 32'h00005A5A, 4'b0011, 0, 32'h0));
    vecs.push_back(mk(0,0,0,1,0,0, 32'h0, 32'h0, 4'h0, 32'h0,
                      C_BRSP, 32'h0, 32'h0, 4'h0, 0, 32'h0));
    // Read 0x200, four wait cycles then ack, RReady low for two cycles
    vecs.push_back(mk(0,0,1,0,0,0, 32'h200, 32'h0, 4'h0, 32'h0,
                      C_IDLE, 32'h0, 32'h0, 4'h0, 0, 32'h0));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(0,0,0,0,0,(i == 4), 32'h0, 32'h0, 4'h0, 32'h12345678,
                        C_RBUS, 32'h200, 32'h0, 4'h0, 0, 32'h0));
    end
    vecs.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 4'h0, 32'h0,
                      C_RRSP, 32'h0, 32'h0, 4'h0, 1, 32'h12345678));
    vecs.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 4'h0, 32'h0,
                      C_RRSP, 32'h0, 32'h0, 4'h0, 1, 32'h12345678));
    vecs.push_back(mk(0,0,0,0,1,0, 32'h0, 32'h0, 4'h0, 32'h0,
                      C_RRSP, 32'h0, 32'h0, 4'h0, 1, 32'h12345678));
    // Spurious ack while idle is ignored
    vecs.push_back(mk(0,0,0,0,0,1, 32'h0, 32'h0, 4'h0, 32'hFFFFFFFF,
                      C_IDLE, 32'h0, 32'h0, 4'h0, 1, 32'h12345678));
    vecs.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 4'h0, 32'h0,
                      C_IDLE, 32'h0, 32'h0, 4'h0, 1, 32'h12345678));

    // Reset state
    tick(); tick(); tick();
    check("reset ctl", 32'(ctl_now()), 32'h0);
    check("reset addr", core_addr, 32'h0);
    check("reset wdata", core_data_out, 32'h0);
    check("reset wstrb", 32'(core_wstrb), 32'h0);
    check("reset rdata", Rdata, 32'h0);
    check1("reset timeout", timeout_o, 1'b0);
    rst_core = 1'b0;
    tick();

    foreach (vecs[i]) begin
      AWvalid = vecs[i].awv; Wvalid = vecs[i].wv; ARvalid = vecs[i].arv;
      Bready = vecs[i].bready; RReady = vecs[i].rready; core_ack = vecs[i].ack;
      AWdata = vecs[i].addr; ARdata = vecs[i].addr; Wdata = vecs[i].wdata;
      Wstrb = vecs[i].strb; core_data_in = vecs[i].rdin;
      check($sformatf("vec%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      if (vecs[i].ctl[4]) begin
        check($sformatf("vec%0d addr", i), core_addr, vecs[i].exp_addr);
        check($sformatf("vec%0d wstrb", i), 32'(core_wstrb), 32'(vecs[i].exp_strb));
      end
      if (vecs[i].ctl[2]) check($sformatf("vec%0d wdata", i), core_data_out, vecs[i].exp_data);
      if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), Rdata, vecs[i].exp_rd);
      tick();
    end
    idle_inputs();
    tick();

    // AW, W and AR together: write first, AR taken after the B handshake
    AWvalid = 1'b1; Wvalid = 1'b1; ARvalid = 1'b1;
    AWdata = 32'h300; ARdata = 32'h400; Wdata = 32'h11112222; Wstrb = 4'hF;
    tick();
    AWvalid = 1'b0; Wvalid = 1'b0; core_ack = 1'b1;
    check1("allv arready wbus", ARready, 1'b0);
    check1("allv we", core_we, 1'b1);
    check("allv waddr", core_addr, 32'h300);
    tick();
    core_ack = 1'b0; Bready = 1'b1;
    check1("allv arready bresp", ARready, 1'b0);
    check1("allv bvalid", Bvalid, 1'b1);
    tick();
    Bready = 1'b0;
    check1("allv arready idle", ARready, 1'b1);
    tick();
    ARvalid = 1'b0; core_ack = 1'b1; core_data_in = 32'hA5A5A5A5;
    check("allv raddr", core_addr, 32'h400);
    check1("allv read we", core_we, 1'b0);
    check1("allv read stb", core_stb, 1'b1);
    tick();
    core_ack = 1'b0; RReady = 1'b1;
    check1("allv rvalid", Rvalid, 1'b1);
    check("allv rdata", Rdata, 32'hA5A5A5A5);
    tick();
    RReady = 1'b0;

    // Timeout on a read with no ack
    ARvalid = 1'b1; ARdata = 32'h500;
    tick();
    ARvalid = 1'b0;
    n = 0; pulses = 0;
    while (core_stb && n < 40) begin
      n++;
      if (timeout_o) pulses++;
      tick();
    end
    check("to stb cycles", 32'(n), 32'd16);
    check("to early pulses", 32'(pulses), 32'd0);
    check1("to pulse", timeout_o, 1'b1);
    check1("to rvalid", Rvalid, 1'b1);
    check("to rdata", Rdata, 32'hDEADBEEF);
    tick();
    check1("to pulse width", timeout_o, 1'b0);
    check1("to rvalid held", Rvalid, 1'b1);
    RReady = 1'b1;
    tick();
    RReady = 1'b0;

    // Ack on the limit cycle wins over timeout
    ARvalid = 1'b1; ARdata = 32'h600;
    tick();
    ARvalid = 1'b0;
    repeat (15) tick();
    check1("lim stb", core_stb, 1'b1);
    core_ack = 1'b1; core_data_in = 32'h600DF00D;
    tick();
    core_ack = 1'b0;
    check1("lim no timeout", timeout_o, 1'b0);
    check1("lim rvalid", Rvalid, 1'b1);
    check("lim rdata", Rdata, 32'h600DF00D);
    RReady = 1'b1;
    tick();
    RReady = 1'b0;

    // Reset during RD_BUS, then a normal read
    ARvalid = 1'b1; ARdata = 32'h700;
    tick();
    ARvalid = 1'b0;
    check1("rst pre stb", core_stb, 1'b1);
    rst_core = 1'b1;
    tick();
    rst_core = 1'b0;
    check("rst mid ctl", 32'(ctl_now()), 32'h0);
    tick();
    ARvalid = 1'b1; ARdata = 32'h704;
    tick();
    ARvalid = 1'b0; core_ack = 1'b1; core_data_in = 32'h87654321;
    check("rst read addr", core_addr, 32'h704);
    tick();
    core_ack = 1'b0; RReady = 1'b1;
    check1("rst read rvalid", Rvalid, 1'b1);
    check("rst read rdata", Rdata, 32'h87654321);
    tick();
    RReady = 1'b0;
    check("rst read idle", 32'(ctl_now()), 32'(C_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_wb_bridge.md
Name: axi_lite_wb_bridge

Overview:
- Sits between the mriscvcore AXI4-Lite-style master ports (AW/W/B/AR/R; no RRESP/BRESP) and the Wishbone core bus (core_cyc/stb/we/wstrb/addr/data, core_ack) served by Controller or the simulation memory.
- Converts one AXI transaction at a time into a single Wishbone classic cycle and returns the result on B or R.
- Includes an ack timeout so an unmapped address cannot hang the core.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, cycles stb may stay high without ack before the bridge aborts; 0 disables the timeout.
- TIMEOUT_RDATA, 32'hDEADBEEF, read data returned on a timed-out read.

Ports:
- clk_core  in  1  core clock; all logic rises on this edge.
- rst_core  in  1  synchronous, active-high reset.
- AWvalid  in  1 / AWready  out  1 / AWdata  in  ADDR_WIDTH / AWprot  in  3: write address channel; AWprot is ignored.
- Wvalid  in  1 / Wready  out  1 / Wdata  in  DATA_WIDTH / Wstrb  in  DATA_WIDTH/8: write data channel.
- Bvalid  out  1 / Bready  in  1: write response channel.
- ARvalid  in  1 / ARready  out  1 / ARdata  in  ADDR_WIDTH / ARprot  in  3: read address channel; ARprot is ignored.
- Rvalid  out  1 / RReady  in  1 / Rdata  out  DATA_WIDTH: read data channel.
- core_cyc, core_stb, core_we  out  1 each: Wishbone control.
- core_wstrb  out  DATA_WIDTH/8: Wishbone byte strobe.
- core_addr  out  ADDR_WIDTH: Wishbone address.
- core_data_out  out  DATA_WIDTH: Wishbone write data.
- core_data_in  in  DATA_WIDTH: Wishbone read data.
- core_ack  in  1: Wishbone acknowledge.
- timeout_o  out  1: one-cycle pulse when a transaction is aborted by timeout.

Behaviour:
- Clock and reset: one clock, clk_core; reset rst_core is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - All ready and valid outputs are 0, core_cyc/stb/we are 0, timeout_o is 0.
  - core_addr, core_data_out, core_wstrb and Rdata are 0; the address, data, strobe and flag registers are cleared.
- States: IDLE, WR_DATA, WR_ADDR, WR_BUS, WR_RESP, RD_BUS, RD_RESP.
- Ready signals are registered. AWready, Wready and ARready are 1 only in IDLE, with these exceptions:
  - Wready is also 1 in WR_DATA.
  - AWready is also 1 in WR_ADDR.
- IDLE:
  - AWvalid&&Wvalid: latch address, data and strobe, then go to WR_BUS.
  - Only AWvalid: latch the address, go to WR_DATA.
  - Only Wvalid: latch data and strobe, go to WR_ADDR.
  - Otherwise ARvalid: latch the address, go to RD_BUS.
  - Write has priority when AW (or W) and AR are valid together; AR is not accepted that cycle.
- WR_DATA: on Wvalid, latch data and strobe, go to WR_BUS. WR_ADDR: on AWvalid, latch the address, go to WR_BUS.
- WR_BUS / RD_BUS:
  - core_cyc = core_stb = 1; core_we = 1 in WR_BUS and 0 in RD_BUS.
  - core_addr, core_data_out and core_wstrb are driven from the latches and stay stable until ack.
  - core_wstrb = 0 for reads.
  - core_ack is honoured in any cycle with stb = 1, including the first.
  - On ack: drop cyc/stb the next cycle. A read captures core_data_in into Rdata on the ack edge.
  - Next state is WR_RESP or RD_RESP.
- Timeout:
  - An 8..32-bit counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to a BUS state and increments each cycle stb is high without ack.
  - When count == TIMEOUT_CYCLES-1 with no ack: drop cyc/stb, pulse timeout_o for one cycle, and go to the RESP state.
  - A read then returns Rdata = TIMEOUT_RDATA.
  - An ack that arrives in the same cycle as the limit wins; no timeout is raised.
- WR_RESP: Bvalid = 1, held until Bready; go to IDLE on the handshake cycle.
- RD_RESP: Rvalid = 1 with Rdata stable, held until RReady; go to IDLE.
- Minimum latency:
  - Write: AW+W handshake at cycle 0, stb at cycle 1, ack at cycle 1, Bvalid at cycle 2.
  - Read: same timing, with Rvalid at cycle 2.
  - The next request is accepted at the earliest in the cycle after the response handshake.
- One transaction is outstanding at a time; there is no pipelining. Spurious core_ack outside a BUS state is ignored.
- Reset mid-transaction: return to IDLE next edge with all outputs at reset values. The pending transaction is dropped and no response is issued.

Decomposition:
- Package axi_wb_bridge_pkg holds the state enum typedef (bridge_state_t) and the default TIMEOUT_RDATA constant.
- No sub-module is required; the timeout counter stays inline.

Test Plan:
- Write, AW and W together, addr 0x0000_0100, data 0xCAFEBABE, strb 4'hF, ack at 1st stb cycle -> AWready and Wready 1 in cycle 0, core_we=1 with addr 0x100 and data 0xCAFEBABE in cycle 1, Bvalid in cycle 2.
- W leads AW by 3 cycles, strb 4'b0011 -> Wready handshake, then AWready, then a single Wishbone write with core_wstrb=0011.
- Read addr 0x200, core_data_in=0x12345678, ack after 4 wait cycles, RReady low for 2 cycles -> cyc/stb high for 5 cycles, Rvalid held with Rdata=0x12345678 until RReady, then back to IDLE.
- AWvalid, Wvalid and ARvalid all asserted together -> write executes first and ARready stays 0; the read is accepted after the Bready handshake.
- TIMEOUT_CYCLES=16, read with no ack -> stb drops after 16 cycles, timeout_o pulses once, Rdata=0xDEADBEEF.
- rst_core asserted during RD_BUS -> the next cycle has cyc=stb=Rvalid=0; a subsequent normal read completes correctly.
